// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter.
//   PAR_NONE / PAR_EVEN / PAR_ODD : encodings of the par_mode input
//   state_e                       : transmitter FSM state encoding
//   par_enabled()                 : 1 when a par_mode value inserts a parity bit
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // 2'b11 is an alias for "no parity".
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: a down-counter that produces a tick on the last
// cycle of every bit period.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   en   : 1 while a frame is in progress; 0 keeps the counter preloaded
//   div  : cycles per bit for the NEXT bit period (0 behaves as 1)
//   tick : 1 on the final cycle of the current bit period
module uart_baud_gen #(
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [BAUD_W-1:0] div,
  output logic              tick
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [BAUD_W-1:0] reload;

  // The counter holds "cycles left after this one", so a divisor of N
  // reloads N-1; a divisor of 0 reloads 0 exactly like a divisor of 1.
  assign reload = (div == '0) ? '0 : div - BAUD_W'(1);
  assign tick   = en && (cnt_q == '0);

  // While disabled the counter keeps reloading, so the first bit of a
  // frame already starts with a full count.
  always_comb begin
    cnt_d = cnt_q - BAUD_W'(1);
    if (!en || tick) cnt_d = reload;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-entry holding register.
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset (aborts any frame)
//   baud_div   : cycles per bit, 0 treated as 1, latched per frame
//   par_mode   : 00 none, 01 even, 10 odd, 11 none, latched per frame
//   stop2      : 1 = two stop bits, latched per frame
//   din        : word to send (DATA_W bits, LSB first)
//   din_valid  : din is offered
//   din_ready  : holding register empty
//   tx_out     : registered serial line, idle high
//   busy       : FSM is not IDLE
//   tx_done    : one-cycle pulse after the last stop bit
//   dbg_state  : current FSM state, for observation only
// Handshake: a word is taken on a rising edge where din_valid and din_ready
// are both 1; din_valid is ignored while din_ready is 0, and din_ready
// depends only on registered state, never combinationally on din_valid.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done,
  output state_e            dbg_state
);

  localparam int CNT_W = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic accept;
  logic load;
  logic tick;

  assign accept    = din_valid && !hold_full_q;
  assign din_ready = !hold_full_q;
  assign busy      = (state_q != IDLE);
  assign tx_out    = tx_q;
  assign tx_done   = done_q;
  assign dbg_state = state_q;

  // baud_d is the divisor of the bit that starts on the next edge, so the
  // counter reload at a frame boundary already uses the new configuration.
  uart_baud_gen #(.BAUD_W(BAUD_W)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .div  (baud_d),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    baud_d      = baud_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    done_d      = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = CNT_W'(1);
          end else begin
            done_d = 1'b1;
            if (hold_full_q) load = 1'b1;
            else             state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: move the held word into the shifter and snapshot the
    // configuration; the parity bit is computed once from the whole word.
    if (load) begin
      state_d     = START;
      shift_d     = hold_q;
      bit_cnt_d   = '0;
      baud_d      = baud_div;
      par_en_d    = par_enabled(par_mode);
      par_bit_d   = (^hold_q) ^ (par_mode == PAR_ODD);
      stop2_d     = stop2;
      hold_full_d = 1'b0;
    end

    // Evaluated after the drain so a coinciding accept leaves the register full.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      baud_q      <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_q      <= baud_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      stop2_q     <= stop2_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param (DATA_W=8, BAUD_W=20).
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int BW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [BW-1:0] baud_div = '0;
  logic [1:0]    par_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready, tx_out, busy, tx_done;
  state_e        dbg_state;

  uart_tx_param #(.DATA_W(DW), .BAUD_W(BW)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .par_mode(par_mode),
    .stop2(stop2), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .tx_out(tx_out), .busy(busy), .tx_done(tx_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, 1 or 2
  // stop bits, every bit repeated max(div,1) times. Appends to exp_q.
  task automatic build_frame(input logic [DW-1:0] w, input logic [BW-1:0] div,
                             input logic [1:0] pm, input logic s2, output int len);
    int n;
    int ones;
    logic [0:0] bits[$];
    n = (div == 0) ? 1 : int'(div);
    ones = 0;
    bits.push_back(1'b0);
    for (int b = 0; b < DW; b++) begin
      bits.push_back(w[b]);
      ones += int'(w[b]);
    end
    if (pm == 2'b01) bits.push_back((ones % 2) == 1);
    if (pm == 2'b10) bits.push_back((ones % 2) == 0);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    len = 0;
    foreach (bits[k]) begin
      for (int c = 0; c < n; c++) begin
        exp_q.push_back(bits[k]);
        len++;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] w0;
    bit            has2;
    logic [DW-1:0] w1;
    logic [BW-1:0] div1;
    logic [1:0]    pm1;
    logic          s21;
    logic [BW-1:0] div2;
    logic [1:0]    pm2;
    logic          s22;
    int            chg_at;    // sample index at which cfg2 is applied, -1 none
    int            exp_len1;  // required length of frame 1, -1 = model only
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver + monitor for one vector ----------------
  task automatic run_vec(input int idx, input vec_t v);
    int len1, len2, total;
    bit cfg2_first;
    string tag;
    tag = $sformatf("v%0d", idx);
    exp_q.delete();
    build_frame(v.w0, v.div1, v.pm1, v.s21, len1);
    total = len1;
    if (v.has2) begin
      cfg2_first = (v.chg_at >= 0) && (v.chg_at < len1);
      if (cfg2_first) build_frame(v.w1, v.div2, v.pm2, v.s22, len2);
      else            build_frame(v.w1, v.div1, v.pm1, v.s21, len2);
      total += len2;
    end

    @(negedge clk);
    baud_div = v.div1; par_mode = v.pm1; stop2 = v.s21;
    din = v.w0; din_valid = 1'b1;
    check({tag, " idle_ready"}, din_ready, 1);
    @(posedge clk);

    fork
      begin : drv
        bit taken;
        if (!v.has2) begin
          @(negedge clk);
          din_valid = 1'b0;
        end else begin
          @(negedge clk);
          din = v.w1;
          taken = 1'b0;
          for (int k = 0; k < 400 && !taken; k++) begin
            @(negedge clk);
            if (din_ready) begin
              @(negedge clk);
              taken = 1'b1;
            end
          end
          din_valid = 1'b0;
        end
      end
      begin : mon
        int bad_tx, bad_done, bad_rdy, bad_busy, fb_tx, meas_len;
        logic e_tx, e_done, e_rdy, e_busy;
        bad_tx = 0; bad_done = 0; bad_rdy = 0; bad_busy = 0; fb_tx = -1; meas_len = -1;
        @(negedge clk);
        check({tag, " hold_full_ready"}, din_ready, 0);
        if (tx_out !== 1'b0) @(negedge clk);
        check({tag, " start_latency"}, tx_out, 0);
        for (int i = 0; i <= total; i++) begin
          if (i > 0) @(negedge clk);
          if (i == v.chg_at) begin
            baud_div = v.div2; par_mode = v.pm2; stop2 = v.s22;
          end
          e_tx   = (i < total) ? exp_q[i] : 1'b1;
          e_done = (i == total) || (v.has2 && i == len1);
          e_rdy  = !(v.has2 && i >= 1 && i < len1);
          e_busy = (i < total);
          if (tx_out !== e_tx) begin
            bad_tx++;
            if (fb_tx < 0) fb_tx = i;
          end
          if (tx_done !== e_done) bad_done++;
          if (din_ready !== e_rdy) bad_rdy++;
          if (busy !== e_busy) bad_busy++;
          if (tx_done === 1'b1 && meas_len < 0) meas_len = i;
        end
        check($sformatf("%s wave_bad_samples(first %0d)", tag, fb_tx), bad_tx, 0);
        check({tag, " done_bad_samples"}, bad_done, 0);
        check({tag, " ready_bad_samples"}, bad_rdy, 0);
        check({tag, " busy_bad_samples"}, bad_busy, 0);
        if (v.exp_len1 > 0) check({tag, " frame_len"}, meas_len, v.exp_len1);
      end
    join
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    int bad_tx, bad_other;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx_out", tx_out, 1);
    check("reset din_ready", din_ready, 1);
    check("reset busy", busy, 0);
    check("reset tx_done", tx_done, 0);
    check("reset state", dbg_state, IDLE);
    rst = 1'b1;
    @(negedge clk);

    //            w0     has2 w1     div1 pm1    s21   div2 pm2    s22  chg  len1
    vecs.push_back('{8'h55, 0, 8'h00, 4, 2'b00, 1'b0, 4, 2'b00, 1'b0, -1, 40});
    vecs.push_back('{8'h07, 0, 8'h00, 4, 2'b01, 1'b0, 4, 2'b01, 1'b0, -1, 44});
    vecs.push_back('{8'h07, 0, 8'h00, 4, 2'b10, 1'b0, 4, 2'b10, 1'b0, -1, 44});
    vecs.push_back('{8'hC3, 0, 8'h00, 0, 2'b00, 1'b1, 0, 2'b00, 1'b1, -1, 11});
    vecs.push_back('{8'hA5, 1, 8'h3C, 4, 2'b00, 1'b0, 4, 2'b00, 1'b0, -1, 40});
    vecs.push_back('{8'h12, 1, 8'h34, 4, 2'b00, 1'b0, 4, 2'b01, 1'b0,  8, 40});
    vecs.push_back('{8'hFF, 0, 8'h00, 1, 2'b11, 1'b1, 1, 2'b11, 1'b1, -1, 11});
    vecs.push_back('{8'h81, 1, 8'h7E, 3, 2'b10, 1'b1, 0, 2'b01, 1'b0,  5, 36});

    foreach (vecs[k]) run_vec(k, vecs[k]);

    // Randomized frames, including mid-frame configuration changes.
    for (int r = 0; r < 12; r++) begin
      v.w0       = DW'($urandom);
      v.has2     = $urandom_range(0, 1) == 1;
      v.w1       = DW'($urandom);
      v.div1     = BW'($urandom_range(0, 5));
      v.pm1      = 2'($urandom_range(0, 3));
      v.s21      = 1'($urandom_range(0, 1));
      v.div2     = BW'($urandom_range(0, 5));
      v.pm2      = 2'($urandom_range(0, 3));
      v.s22      = 1'($urandom_range(0, 1));
      v.chg_at   = $urandom_range(1, 5);
      v.exp_len1 = -1;
      run_vec(100 + r, v);
    end

    // Reset during the 3rd data bit with a second word held.
    @(negedge clk);
    baud_div = 4; par_mode = 2'b00; stop2 = 1'b0;
    din = 8'h9C; din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din = 8'h66;
    @(negedge clk);
    check("rst_seq start_bit", tx_out, 0);
    @(negedge clk);
    din_valid = 1'b0;
    check("rst_seq word_held", din_ready, 0);
    repeat (12) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_seq tx_out", tx_out, 1);
    check("rst_seq din_ready", din_ready, 1);
    check("rst_seq busy", busy, 0);
    check("rst_seq tx_done", tx_done, 0);
    rst = 1'b1;
    bad_tx = 0; bad_other = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1) bad_tx++;
      if (tx_done !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) bad_other++;
    end
    check("rst_seq line_stays_idle", bad_tx, 0);
    check("rst_seq no_done_no_busy", bad_other, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter BAUD_W, default 20, width of the baud divisor.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is clocked on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port baud_div  input  BAUD_W  clock cycles per bit; 0 is treated as 1.
REQ-006 SHALL have port par_mode  input  2  parity select: 00 none, 01 even, 10 odd, 11 none.
REQ-007 SHALL have port stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-008 SHALL have port din  input  DATA_W  word to transmit.
REQ-009 SHALL have port din_valid  input  1  din is offered.
REQ-010 SHALL have port din_ready  output  1  holding register is empty.
REQ-011 SHALL have port tx_out  output  1  serial line, idle high, registered.
REQ-012 SHALL have port busy  output  1  FSM is in any state other than IDLE.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-014 SHALL accept a word on a rising edge where din_valid and din_ready are both 1, loading it into a one-entry holding register.
REQ-015 SHALL hold din_ready at 0 while the holding register is full; din_valid SHALL be ignored while din_ready is 0.
REQ-016 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-017 SHALL take the transition IDLE->START on the edge after the holding register becomes full. On that same edge it SHALL move the word into the shifter, clear the holding register, and latch baud_div, par_mode and stop2 into frame-local registers.
REQ-018 SHALL therefore drive tx_out low no later than 2 cycles after the accept edge.
REQ-019 SHALL hold each bit for exactly max(baud_div,1) cycles, using a down-counter that reloads on every bit boundary.
REQ-020 SHALL send DATA_W data bits LSB first, counted by a bit counter sized for DATA_W.
REQ-021 SHALL insert a PARITY bit only when the latched par_mode is 01 or 10. Even parity SHALL make the total number of ones over data+parity even; odd parity SHALL make it odd.
REQ-022 SHALL send 1 or 2 STOP bits (tx_out=1) according to the latched stop2.
REQ-023 SHALL produce a frame of (1+DATA_W+P+S)*max(baud_div,1) cycles, where P is 0 or 1 and S is 1 or 2.
REQ-024 SHALL pulse tx_done high for exactly one cycle, on the cycle after the last stop bit's final cycle.
REQ-025 SHALL go from the end of STOP directly to START when the holding register is full at that point, re-latching the configuration, so that no idle cycle appears between frames.
REQ-026 SHALL return from the end of STOP to IDLE, with tx_out=1, when the holding register is empty.
REQ-027 SHALL ignore changes to baud_div, par_mode and stop2 in the middle of a frame.
REQ-028 SHALL give priority to the FSM draining the holding register when an accept and a drain coincide on the same edge. The new word SHALL enter the holding register, and din_ready SHALL stay 0.

Reset
REQ-029 SHALL, on the first rising edge with rst=0, reset: FSM=IDLE, tx_out=1, din_ready=1, busy=0, tx_done=0, holding register empty, all counters 0.
REQ-030 SHALL abort any frame in progress when reset occurs mid-frame; tx_out SHALL be 1 from the next edge and the held word SHALL be discarded.

Structure
REQ-031 SHALL take the parity-mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state encoding from shared package uart_pkg.
REQ-032 SHALL place the bit-period down-counter and tick generation in sub-module uart_baud_gen, with ports clk, rst, en, div, tick.
REQ-033 SHALL keep the bit counter and shifter in the top level, stored in registers with the same reset behaviour as REQ-029.

Verification
REQ-034 SHALL cover: DATA_W=8, baud_div=4, par_mode=00, stop2=0, din=0x55 -> tx_out bits 0,1,0,1,0,1,0,1,0,1 at 4 cycles each, then tx_done pulse; frame is 40 cycles.
REQ-035 SHALL cover: din=0x07 with par_mode=01 -> parity bit 1; with par_mode=10 -> parity bit 0; frame is 44 cycles at baud_div=4.
REQ-036 SHALL cover: back-to-back words 0xA5 then 0x3C, valid held high -> the second start bit immediately follows the first stop bit; din_ready is 0 for exactly the spans in which the holding register is full.
REQ-037 SHALL cover: baud_div=0, stop2=1 -> 1-cycle bits, 11-cycle frame.
REQ-038 SHALL cover: rst=0 applied during the 3rd data bit with a word held -> tx_out=1, din_ready=1 and busy=0 after the next edge; no tx_done pulse.
REQ-039 SHALL cover: par_mode changed from 00 to 01 mid-frame -> the current frame has no parity bit, and the next frame carries one.
